gold_seq_ctrl: RTL and testbench

- Scheduler that sequences the Gold-code generator through a programmable list of second-polynomial seeds.
- Each seed is issued over the existing code2/tvalid/ready handshake, repeated REPEAT times, and each repetition is timed for exactly N chips.
- Drives the chip-gating signal and the epoch/done markers used downstream.
- Sits between the PLL-clocked control plane and the Gold generator, replacing the free-running shift generator when scheduled code hopping is needed.

---
 rtl/gold_seq_ctrl_if.sv | 11 +
 rtl/gold_seq_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_gold_seq_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/gold_seq_ctrl_if.sv
// Seed handshake between the sequencer (master) and the Gold generator (slave).
interface gold_seq_ctrl_if #(
  parameter int LENGTH = 6
) ();
  logic [LENGTH-1:0] code2;
  logic              tvalid;
  logic              ready;

  modport master (output code2, output tvalid, input ready);
  modport slave  (input code2, input tvalid, output ready);
endinterface

// File: rtl/gold_seq_ctrl.sv
// Sequences the Gold generator through a programmable list of seeds.
// Each seed is handed over on the code2/tvalid/ready handshake, played for
// REPEAT periods of N chips, and every period is re-handshaked so the
// generator restarts its phase.
module gold_seq_ctrl #(
  parameter int N      = 63,
  parameter int LENGTH = $clog2(N),
  parameter int REPEAT = 2,
  parameter int IDX_W  = 4
) (
  input  logic              clkin,
  input  logic              rstn,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              loop_i,
  input  logic [LENGTH-1:0] seed_base_i,
  input  logic [LENGTH-1:0] seed_step_i,
  input  logic [IDX_W-1:0]  num_codes_i,
  gold_seq_ctrl_if.master   gif,
  output logic              gating_o,
  output logic              epoch_o,
  output logic [IDX_W-1:0]  code_idx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [CNT_W-1:0]  LAST_CHIP = CNT_W'(N - 1);
  localparam logic [REP_W-1:0]  LAST_REP  = REP_W'(REPEAT - 1);
  localparam logic [CNT_W-1:0]  CHIP_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [REP_W-1:0]  REP_ONE   = {{(REP_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]  IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [LENGTH-1:0] SEED_ONE  = {{(LENGTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  chip_cnt, chip_cnt_nxt;
  logic [REP_W-1:0]  rep, rep_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [IDX_W-1:0]  num_last, num_last_nxt;
  logic [LENGTH-1:0] acc, acc_nxt;
  logic [LENGTH-1:0] base, base_nxt;
  logic [LENGTH-1:0] step, step_nxt;
  logic [LENGTH-1:0] code2, code2_nxt;
  logic              loop_en, loop_en_nxt;
  logic              stop_pending, stop_pending_nxt;
  logic              tvalid, tvalid_nxt;
  logic              gating, gating_nxt;
  logic              done, done_nxt;
  logic              last_chip, last_rep, last_idx, stop_now;

  // An all-zero state would lock the LFSR, so zero is presented as one.
  function automatic logic [LENGTH-1:0] seed_fix(input logic [LENGTH-1:0] v);
    if (v == {LENGTH{1'b0}}) begin
      seed_fix = SEED_ONE;
    end else begin
      seed_fix = v;
    end
  endfunction

  assign last_chip = (chip_cnt == LAST_CHIP);
  assign last_rep  = (rep == LAST_REP);
  assign last_idx  = (idx == num_last);
  // A stop arriving on the last chip still ends the current period.
  assign stop_now  = stop_pending | stop_i | (last_rep & last_idx & ~loop_en);

  assign gif.code2  = code2;
  assign gif.tvalid = tvalid;
  assign gating_o   = gating;
  assign epoch_o    = tvalid & gif.ready;
  assign code_idx_o = idx;
  assign busy_o     = (state != IDLE);
  assign done_o     = done;

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_nxt        = state;
    chip_cnt_nxt     = chip_cnt;
    rep_nxt          = rep;
    idx_nxt          = idx;
    num_last_nxt     = num_last;
    acc_nxt          = acc;
    base_nxt         = base;
    step_nxt         = step;
    code2_nxt        = code2;
    loop_en_nxt      = loop_en;
    stop_pending_nxt = stop_pending;
    tvalid_nxt       = tvalid;
    gating_nxt       = gating;
    done_nxt         = 1'b0;
    case (state)
      IDLE: begin
        stop_pending_nxt = 1'b0;
        if (start_i) begin
          base_nxt     = seed_base_i;
          step_nxt     = seed_step_i;
          loop_en_nxt  = loop_i;
          num_last_nxt = (num_codes_i == {IDX_W{1'b0}}) ? {IDX_W{1'b0}} : (num_codes_i - IDX_ONE);
          idx_nxt      = '0;
          rep_nxt      = '0;
          chip_cnt_nxt = '0;
          acc_nxt      = seed_base_i;
          code2_nxt    = seed_fix(seed_base_i);
          tvalid_nxt   = 1'b1;
          state_nxt    = LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD: begin
        stop_pending_nxt = stop_pending | stop_i;
        if (tvalid & gif.ready) begin
          tvalid_nxt   = 1'b0;
          gating_nxt   = 1'b1;
          chip_cnt_nxt = '0;
          state_nxt    = RUN;
        end else begin
          state_nxt = LOAD;
        end
      end
      RUN: begin
        stop_pending_nxt = stop_pending | stop_i;
        if (last_chip) begin
          gating_nxt   = 1'b0;
          chip_cnt_nxt = '0;
          if (stop_now) begin
            state_nxt        = IDLE;
            done_nxt         = 1'b1;
            stop_pending_nxt = 1'b0;
            rep_nxt          = '0;
          end else begin
            state_nxt  = LOAD;
            tvalid_nxt = 1'b1;
            if (!last_rep) begin
              rep_nxt = rep + REP_ONE;
            end else begin
              rep_nxt = '0;
              if (last_idx) begin
                idx_nxt = '0;
                acc_nxt = base;
              end else begin
                idx_nxt = idx + IDX_ONE;
                acc_nxt = acc + step;
              end
            end
            code2_nxt = seed_fix(acc_nxt);
          end
        end else begin
          chip_cnt_nxt = chip_cnt + CHIP_ONE;
        end
      end
      default: begin
        state_nxt  = IDLE;
        tvalid_nxt = 1'b0;
        gating_nxt = 1'b0;
      end
    endcase
  end

  // State and registered-output update; reset aborts with everything cleared.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      chip_cnt     <= '0;
      rep          <= '0;
      idx          <= '0;
      num_last     <= '0;
      acc          <= '0;
      base         <= '0;
      step         <= '0;
      code2        <= '0;
      loop_en      <= 1'b0;
      stop_pending <= 1'b0;
      tvalid       <= 1'b0;
      gating       <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      chip_cnt     <= chip_cnt_nxt;
      rep          <= rep_nxt;
      idx          <= idx_nxt;
      num_last     <= num_last_nxt;
      acc          <= acc_nxt;
      base         <= base_nxt;
      step         <= step_nxt;
      code2        <= code2_nxt;
      loop_en      <= loop_en_nxt;
      stop_pending <= stop_pending_nxt;
      tvalid       <= tvalid_nxt;
      gating       <= gating_nxt;
      done         <= done_nxt;
    end
  end

endmodule

// File: tb/tb_gold_seq_ctrl.sv
// Self-checking bench for gold_seq_ctrl: directed scenarios plus randomized
// runs, compared against a list-level model of the seed schedule.
module tb_gold_seq_ctrl;

  localparam int N      = 63;
  localparam int LENGTH = 6;
  localparam int REPEAT = 2;
  localparam int IDX_W  = 4;

  logic              clk;
  logic              rstn;
  logic              start_i;
  logic              stop_i;
  logic              loop_i;
  logic [LENGTH-1:0] seed_base_i;
  logic [LENGTH-1:0] seed_step_i;
  logic [IDX_W-1:0]  num_codes_i;
  logic              gating;
  logic              epoch;
  logic [IDX_W-1:0]  code_idx;
  logic              busy;
  logic              done;

  int errors = 0;
  int checks = 0;

  gold_seq_ctrl_if #(.LENGTH(LENGTH)) gif ();

  gold_seq_ctrl #(.N(N), .LENGTH(LENGTH), .REPEAT(REPEAT), .IDX_W(IDX_W)) dut (
    .clkin       (clk),
    .rstn        (rstn),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .loop_i      (loop_i),
    .seed_base_i (seed_base_i),
    .seed_step_i (seed_step_i),
    .num_codes_i (num_codes_i),
    .gif         (gif),
    .gating_o    (gating),
    .epoch_o     (epoch),
    .code_idx_o  (code_idx),
    .busy_o      (busy),
    .done_o      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_code2"}, 32'(gif.code2), 32'd0);
    chk({tag, "_tvalid"}, 32'(gif.tvalid), 32'd0);
    chk({tag, "_gating"}, 32'(gating), 32'd0);
    chk({tag, "_epoch"}, 32'(epoch), 32'd0);
    chk({tag, "_idx"}, 32'(code_idx), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Expected seed of period p: list entry (p / REPEAT) mod num, base + i*step mod 2^LENGTH, 0 -> 1.
  function automatic int model_seed(input int base, input int step, input int num_eff, input int p);
    int i;
    int v;
    i = (p / REPEAT) % num_eff;
    v = (base + i * step) % (1 << LENGTH);
    if (v == 0) v = 1;
    return v;
  endfunction

  // One complete run from start to done (or until an injected reset).
  // stall_mode: 0 = ready always 1, 1 = 10-cycle stall on first LOAD, 2 = random stalls.
  task automatic run_seq(input int base, input int step, input int num, input int lp,
                         input int stop_p, input int stop_c, input int stop_load_p,
                         input int stall_mode, input int reset_p, input int start_p);
    int num_eff;
    int total;
    int idx_e;
    int seed_e;
    int stall;
    num_eff = (num == 0) ? 1 : num;
    if (stop_p >= 0) total = stop_p + 1;
    else if (stop_load_p >= 0) total = stop_load_p + 1;
    else total = num_eff * REPEAT;

    seed_base_i = 6'(base);
    seed_step_i = 6'(step);
    num_codes_i = 4'(num);
    loop_i      = 1'(lp);
    start_i     = 1'b1;
    stop_i      = 1'b0;
    @(negedge clk);
    start_i     = 1'b0;
    seed_base_i = 6'($urandom);
    seed_step_i = 6'($urandom);
    num_codes_i = 4'($urandom);
    loop_i      = 1'($urandom_range(0, 1));

    for (int p = 0; p < total; p++) begin
      idx_e  = (p / REPEAT) % num_eff;
      seed_e = model_seed(base, step, num_eff, p);
      if (stall_mode == 1) stall = (p == 0) ? 10 : 0;
      else if (stall_mode == 2) stall = $urandom_range(0, 3);
      else stall = 0;
      for (int s = 0; s <= stall; s++) begin
        gif.ready = (s == stall);
        stop_i    = (p == stop_load_p) && (s == 0);
        #1;
        chk("load_tvalid", 32'(gif.tvalid), 32'd1);
        chk("load_code2", 32'(gif.code2), 32'(seed_e));
        chk("load_gating", 32'(gating), 32'd0);
        chk("load_epoch", 32'(epoch), 32'(s == stall));
        chk("load_idx", 32'(code_idx), 32'(idx_e));
        chk("load_busy", 32'(busy), 32'd1);
        @(negedge clk);
      end
      stop_i = 1'b0;
      for (int c = 0; c < N; c++) begin
        gif.ready = 1'($urandom_range(0, 1));
        stop_i    = (p == stop_p) && (c == stop_c);
        start_i   = (p == start_p) && (c == 10);
        if (p == reset_p && c == 30) begin
          stop_i  = 1'b0;
          start_i = 1'b0;
          rstn    = 1'b0;
          #1;
          chk_all_zero("midrst");
          @(negedge clk);
          chk("midrst_no_done", 32'(done), 32'd0);
          rstn = 1'b1;
          @(negedge clk);
          return;
        end
        #1;
        chk("run_gating", 32'(gating), 32'd1);
        chk("run_tvalid", 32'(gif.tvalid), 32'd0);
        chk("run_done", 32'(done), 32'd0);
        if (c == 0) chk("run_idx", 32'(code_idx), 32'(idx_e));
        @(negedge clk);
      end
      stop_i  = 1'b0;
      start_i = 1'b0;
    end
    #1;
    chk("end_done", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_gating", 32'(gating), 32'd0);
    chk("end_tvalid", 32'(gif.tvalid), 32'd0);
    @(negedge clk);
    chk("end_done_pulse", 32'(done), 32'd0);
    chk("end_idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int b;
    int st;
    int nm;
    int lp;
    int sp;
    rstn        = 1'b0;
    start_i     = 1'b0;
    stop_i      = 1'b0;
    loop_i      = 1'b0;
    seed_base_i = '0;
    seed_step_i = '0;
    num_codes_i = '0;
    gif.ready   = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // stop in IDLE is ignored
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    #1;
    chk("idle_stop_busy", 32'(busy), 32'd0);
    @(negedge clk);

    // base case: 5,5,8,8,11,11,14,14 then done
    run_seq(5, 3, 4, 0, -1, -1, -1, 0, -1, -1);
    // zero substitution with looping, stopped mid period 4
    run_seq(61, 3, 2, 1, 4, 20, -1, 0, -1, -1);
    // 10-cycle ready stall on the first LOAD
    run_seq(10, 7, 1, 0, -1, -1, -1, 1, -1, -1);
    // reset at chip 30 of the third period
    run_seq(9, 2, 3, 0, -1, -1, -1, 0, 2, -1);
    // fresh start after reset, with a start pulse during RUN
    run_seq(20, 5, 2, 0, -1, -1, -1, 0, -1, 1);
    // num_codes = 0 behaves as a single-entry list
    run_seq(33, 4, 0, 0, -1, -1, -1, 0, -1, -1);
    // stop on the very last chip of a looping run
    run_seq(7, 1, 3, 1, 1, N - 1, -1, 0, -1, -1);
    // stop issued during LOAD lets that period complete
    run_seq(2, 9, 3, 0, -1, -1, 1, 0, -1, -1);

    for (int k = 0; k < 4; k++) begin
      b  = $urandom_range(0, 63);
      st = $urandom_range(0, 63);
      nm = $urandom_range(0, 4);
      lp = $urandom_range(0, 1);
      sp = (lp == 1) ? $urandom_range(0, 6) : -1;
      run_seq(b, st, nm, lp, sp, $urandom_range(0, N - 1), -1, 2, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
